// File: rtl/alu_op_issuer.sv
// alu_op_issuer: valid/ready request sequencer driving the 8-bit ALU begin_op/alu_done handshake.
// Define ALU_ISSUE_TIMEOUT_EN to abort mul/div operations that never report alu_done.
module alu_op_issuer #(
  parameter int ADDSUB_LAT = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_opcode,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  output logic        begin_op,
  output logic [1:0]  opcode,
  output logic [7:0]  op_a,
  output logic [7:0]  op_b,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        alu_abort,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [1:0]  rsp_opcode,
  output logic        rsp_err,
  output logic [15:0] ops_done
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3;
  localparam int CW = $clog2(((ADDSUB_LAT > TIMEOUT_CYCLES) ? ADDSUB_LAT : TIMEOUT_CYCLES) + 1);
  logic [1:0] state;
  logic [CW-1:0] wcnt;
  logic addsub, lat_hit, done_hit, to_hit, capture;
  assign req_ready = state == IDLE;
  assign begin_op = state == ISSUE;
  assign rsp_valid = state == RESP;
  assign addsub = ~opcode[1];
  assign lat_hit = addsub && wcnt == CW'(ADDSUB_LAT - 1);
  assign done_hit = !addsub && alu_done;
  assign capture = state == WAIT && (lat_hit || done_hit || to_hit);
`ifdef ALU_ISSUE_TIMEOUT_EN
  // a simultaneous alu_done takes priority over the timeout
  assign to_hit = !addsub && !alu_done && wcnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_err <= 1'b0;
      alu_abort <= 1'b0;
    end else begin
      alu_abort <= capture && to_hit;
      rsp_err <= capture ? to_hit : rsp_err;
    end
  end
`else
  assign to_hit = 1'b0;
  assign rsp_err = 1'b0;
  assign alu_abort = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      wcnt <= '0;
      opcode <= '0;
      op_a <= '0;
      op_b <= '0;
      rsp_result <= '0;
      rsp_opcode <= '0;
      ops_done <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          opcode <= req_opcode;
          op_a <= req_a;
          op_b <= req_b;
          state <= ISSUE;
        end
        ISSUE: begin
          wcnt <= '0;
          state <= WAIT;
        end
        WAIT: begin
          wcnt <= wcnt + 1'b1;
          if (capture) begin
            state <= RESP;
            rsp_opcode <= opcode;
            rsp_result <= to_hit ? 16'h0000 : addsub ? {8'h00, alu_result[7:0]} : alu_result;
          end
        end
        default: if (rsp_ready) begin
          ops_done <= ops_done + 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_op_issuer.sv
// tb_alu_op_issuer: directed and randomized checks of alu_op_issuer against a request-level model.
module tb_alu_op_issuer;
  localparam int LAT = 1;
  localparam int TO = 8;
`ifdef ALU_ISSUE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 0, reset = 0, req_valid = 0, alu_done = 0, rsp_ready = 0;
  logic req_ready, begin_op, alu_abort, rsp_valid, rsp_err;
  logic [1:0] req_opcode = 0, opcode, rsp_opcode;
  logic [7:0] req_a = 0, req_b = 0, op_a, op_b;
  logic [15:0] alu_result, rsp_result, ops_done;
  logic [15:0] exp_ops = 0;
  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  alu_op_issuer #(.ADDSUB_LAT(LAT), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b), .begin_op(begin_op),
    .opcode(opcode), .op_a(op_a), .op_b(op_b), .alu_done(alu_done),
    .alu_result(alu_result), .alu_abort(alu_abort), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_opcode(rsp_opcode),
    .rsp_err(rsp_err), .ops_done(ops_done)
  );

  // Response expected for a request: add/sub zero-extended 8-bit, signed 16-bit product, {rem, quo}
  function automatic logic [15:0] ref_result(logic [1:0] op, logic [7:0] a, logic [7:0] b);
    logic [7:0] s;
    int p;
    s = op[0] ? a - b : a + b;
    p = int'($signed(a)) * int'($signed(b));
    if (!op[1]) return {8'h00, s};
    if (!op[0]) return p[15:0];
    return {a % b, a / b};
  endfunction

  // ALU stand-in drives junk in the upper byte for add/sub, which the issuer must drop
  function automatic logic [15:0] alu_model(logic [1:0] op, logic [7:0] a, logic [7:0] b);
    logic [15:0] r;
    r = ref_result(op, a, b);
    return op[1] ? r : {8'hA5 ^ {6'b0, op}, r[7:0]};
  endfunction

  assign alu_result = alu_model(opcode, op_a, op_b);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    req_opcode = op; req_a = a; req_b = b; req_valid = 1;
    for (int i = 0; i < 200 && !req_ready; i++) tick();
    tick();
    req_valid = 0;
  endtask

  task automatic handshake();
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    exp_ops = exp_ops + 1;
  endtask

  task automatic test_reset();
    reset = 0;
    tick(); tick();
    checks++;
    if ({begin_op, rsp_valid, alu_abort, rsp_err} !== 4'b0000) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 0000", {begin_op, rsp_valid, alu_abort, rsp_err});
    end
    checks++;
    if ({ops_done, rsp_result, rsp_opcode, opcode, op_a, op_b} !== 52'h0) begin
      fails++; $display("FAIL reset_regs: got %h expected 0", {ops_done, rsp_result, rsp_opcode, opcode, op_a, op_b});
    end
    reset = 1;
    tick();
    checks++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_add();
    send(2'b00, 8'h7F, 8'h01);
    checks++;
    if ({begin_op, rsp_valid} !== 2'b10) begin fails++; $display("FAIL add_issue: got %b expected 10", {begin_op, rsp_valid}); end
    tick();
    checks++;
    if ({begin_op, rsp_valid} !== 2'b00) begin fails++; $display("FAIL add_wait: got %b expected 00", {begin_op, rsp_valid}); end
    for (int i = 1; i < LAT; i++) tick();
    tick();
    checks++;
    if (rsp_valid !== 1 || rsp_result !== 16'h0080 || rsp_err !== 0) begin
      fails++; $display("FAIL add_rsp: got v=%b r=%h e=%b expected v=1 r=0080 e=0", rsp_valid, rsp_result, rsp_err);
    end
    handshake();
    checks++;
    if (ops_done !== exp_ops || req_ready !== 1) begin
      fails++; $display("FAIL add_count: got %h rdy=%b expected %h rdy=1", ops_done, req_ready, exp_ops);
    end
  endtask

  task automatic test_mul();
    int d;
    d = TO_EN ? TO : 18;
    send(2'b10, 8'hFD, 8'h05);
    for (int c = 0; c < d; c++) begin
      tick();
      checks++;
      if ({opcode, op_a, op_b, rsp_valid, begin_op} !== {2'b10, 8'hFD, 8'h05, 2'b00}) begin
        fails++; $display("FAIL mul_hold: got %h expected %h", {opcode, op_a, op_b, rsp_valid, begin_op}, {2'b10, 8'hFD, 8'h05, 2'b00});
      end
    end
    alu_done = 1;
    tick();
    alu_done = 0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_opcode, rsp_result} !== {2'b10, 2'b10, 16'hFFF1}) begin
      fails++; $display("FAIL mul_rsp: got v=%b e=%b op=%b r=%h expected v=1 e=0 op=10 r=fff1", rsp_valid, rsp_err, rsp_opcode, rsp_result);
    end
    handshake();
    checks++;
    if (ops_done !== exp_ops) begin fails++; $display("FAIL mul_count: got %h expected %h", ops_done, exp_ops); end
  endtask

  task automatic test_backpressure();
    send(2'b11, 8'd100, 8'd7);
    tick();
    alu_done = 1;
    tick();
    alu_done = 0;
    req_opcode = 2'b00; req_a = 8'h11; req_b = 8'h22; req_valid = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({rsp_valid, req_ready, begin_op, rsp_opcode, rsp_result} !== {3'b100, 2'b11, 16'h020E}) begin
        fails++; $display("FAIL bp_hold: got v=%b rdy=%b b=%b op=%b r=%h expected v=1 rdy=0 b=0 op=11 r=020e",
                          rsp_valid, req_ready, begin_op, rsp_opcode, rsp_result);
      end
    end
    handshake();
    checks++;
    if (ops_done !== exp_ops || req_ready !== 1 || begin_op !== 0) begin
      fails++; $display("FAIL bp_release: got cnt=%h rdy=%b b=%b expected cnt=%h rdy=1 b=0", ops_done, req_ready, begin_op, exp_ops);
    end
    tick();
    req_valid = 0;
    checks++;
    if ({begin_op, op_a, op_b} !== {1'b1, 8'h11, 8'h22}) begin
      fails++; $display("FAIL bp_second: got %h expected 11122", {begin_op, op_a, op_b});
    end
    for (int i = 0; i <= LAT; i++) tick();
    checks++;
    if (rsp_valid !== 1 || rsp_result !== 16'h0033) begin
      fails++; $display("FAIL bp_second_rsp: got v=%b r=%h expected v=1 r=0033", rsp_valid, rsp_result);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    int pos[3];
    int np = 0;
    logic [7:0] a, b;
    a = 8'($urandom); b = 8'($urandom);
    rsp_ready = 1;
    req_opcode = 2'b01; req_a = a; req_b = b; req_valid = 1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (begin_op && np < 3) begin pos[np] = t; np++; if (np == 3) req_valid = 0; end
    end
    rsp_ready = 0;
    exp_ops = exp_ops + 3;
    checks++;
    if (np !== 3 || pos[1] - pos[0] !== 3 + LAT || pos[2] - pos[1] !== 3 + LAT) begin
      fails++; $display("FAIL b2b_interval: got n=%0d at %0d,%0d,%0d expected 3 pulses spaced %0d", np, pos[0], pos[1], pos[2], 3 + LAT);
    end
    checks++;
    if (ops_done !== exp_ops || rsp_result !== ref_result(2'b01, a, b) || req_ready !== 1) begin
      fails++; $display("FAIL b2b_result: got cnt=%h r=%h rdy=%b expected cnt=%h r=%h rdy=1", ops_done, rsp_result, req_ready, exp_ops, ref_result(2'b01, a, b));
    end
  endtask

`ifdef ALU_ISSUE_TIMEOUT_EN
  task automatic test_timeout();
    int aborts = 0;
    send(2'b10, 8'h12, 8'h34);
    for (int c = 1; c <= TO; c++) begin
      tick();
      aborts += int'(alu_abort);
      checks++;
      if (rsp_valid !== 0) begin fails++; $display("FAIL to_early: got v=%b at wait %0d expected 0", rsp_valid, c); end
    end
    tick();
    aborts += int'(alu_abort);
    checks++;
    if ({rsp_valid, rsp_err, alu_abort, rsp_result} !== {3'b111, 16'h0}) begin
      fails++; $display("FAIL to_rsp: got v=%b e=%b ab=%b r=%h expected 1 1 1 0000", rsp_valid, rsp_err, alu_abort, rsp_result);
    end
    for (int i = 0; i < 3; i++) begin tick(); aborts += int'(alu_abort); end
    checks++;
    if (aborts !== 1 || rsp_valid !== 1 || rsp_err !== 1) begin
      fails++; $display("FAIL to_abort_once: got aborts=%0d v=%b e=%b expected 1 1 1", aborts, rsp_valid, rsp_err);
    end
    handshake();
    send(2'b10, 8'h03, 8'h04);
    for (int c = 1; c <= TO; c++) tick();
    alu_done = 1;
    tick();
    alu_done = 0;
    checks++;
    if ({rsp_valid, rsp_err, alu_abort, rsp_result} !== {3'b100, 16'h000C}) begin
      fails++; $display("FAIL to_done_wins: got v=%b e=%b ab=%b r=%h expected 1 0 0 000c", rsp_valid, rsp_err, alu_abort, rsp_result);
    end
    handshake();
  endtask
`else
  task automatic test_no_timeout();
    logic bad = 0;
    send(2'b10, 8'h12, 8'h34);
    for (int c = 0; c < 80; c++) begin tick(); bad |= rsp_valid | alu_abort | rsp_err; end
    checks++;
    if (bad !== 0) begin fails++; $display("FAIL no_timeout_wait: got early response/abort=%b expected 0", bad); end
    alu_done = 1;
    tick();
    alu_done = 0;
    checks++;
    if (rsp_valid !== 1 || rsp_err !== 0 || rsp_result !== ref_result(2'b10, 8'h12, 8'h34)) begin
      fails++; $display("FAIL no_timeout_rsp: got v=%b e=%b r=%h expected 1 0 %h", rsp_valid, rsp_err, rsp_result, ref_result(2'b10, 8'h12, 8'h34));
    end
    handshake();
  endtask
`endif

  task automatic test_reset_mid_wait();
    send(2'b10, 8'h44, 8'h55);
    tick(); tick(); tick();
    reset = 0;
    tick();
    reset = 1;
    exp_ops = 0;
    checks++;
    if ({rsp_valid, begin_op, alu_abort} !== 3'b000 || ops_done !== exp_ops || op_a !== 0) begin
      fails++; $display("FAIL rst_mid: got v=%b b=%b ab=%b cnt=%h a=%h expected 0 0 0 0000 00", rsp_valid, begin_op, alu_abort, ops_done, op_a);
    end
    alu_done = 1;
    tick();
    alu_done = 0;
    tick();
    checks++;
    if (rsp_valid !== 0 || req_ready !== 1 || ops_done !== exp_ops) begin
      fails++; $display("FAIL rst_late_done: got v=%b rdy=%b cnt=%h expected 0 1 %h", rsp_valid, req_ready, ops_done, exp_ops);
    end
  endtask

  task automatic test_spurious_done();
    alu_done = 1;
    tick(); tick();
    alu_done = 0;
    tick();
    checks++;
    if (rsp_valid !== 0 || req_ready !== 1 || ops_done !== exp_ops) begin
      fails++; $display("FAIL spur_idle: got v=%b rdy=%b cnt=%h expected 0 1 %h", rsp_valid, req_ready, ops_done, exp_ops);
    end
    send(2'b01, 8'h10, 8'h20);
    tick();
    alu_done = 1;
    for (int i = 1; i < LAT; i++) tick();
    tick();
    alu_done = 0;
    checks++;
    if (rsp_valid !== 1 || rsp_result !== 16'h00F0 || rsp_opcode !== 2'b01) begin
      fails++; $display("FAIL spur_add: got v=%b r=%h op=%b expected 1 00f0 01", rsp_valid, rsp_result, rsp_opcode);
    end
    handshake();
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [7:0] a, b;
    logic [15:0] exp;
    int d, rd, lat, got;
    bit to, spur;
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      a = 8'($urandom); b = 8'($urandom);
      if (op == 2'b11 && b == 0) b = 8'd1;
      d = int'($urandom_range(1, 12));
      rd = int'($urandom_range(0, 3));
      spur = 1'($urandom);
      to = TO_EN && op[1] && d > TO;
      lat = !op[1] ? LAT : to ? TO : d;
      exp = to ? 16'h0 : ref_result(op, a, b);
      send(op, a, b);
      got = -1;
      for (int c = 0; c <= 20 && got < 0; c++) begin
        alu_done = (c == d) || (c == 0 && spur);
        tick();
        alu_done = 0;
        if (rsp_valid) got = c;
      end
      checks++;
      if (got !== lat) begin fails++; $display("FAIL rnd_latency[%0d]: op=%b got %0d expected %0d", n, op, got, lat); end
      checks++;
      if ({rsp_result, rsp_opcode, rsp_err, alu_abort} !== {exp, op, to, to}) begin
        fails++; $display("FAIL rnd_rsp[%0d]: got r=%h op=%b e=%b ab=%b expected r=%h op=%b e=%b ab=%b",
                          n, rsp_result, rsp_opcode, rsp_err, alu_abort, exp, op, to, to);
      end
      for (int i = 0; i < rd; i++) tick();
      checks++;
      if (rsp_valid !== 1 || rsp_result !== exp || alu_abort !== (rd == 0 ? to : 1'b0)) begin
        fails++; $display("FAIL rnd_hold[%0d]: got v=%b r=%h ab=%b expected v=1 r=%h", n, rsp_valid, rsp_result, alu_abort, exp);
      end
      handshake();
      checks++;
      if (ops_done !== exp_ops || req_ready !== 1) begin
        fails++; $display("FAIL rnd_count[%0d]: got %h rdy=%b expected %h rdy=1", n, ops_done, req_ready, exp_ops);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_backpressure();
    test_back_to_back();
`ifdef ALU_ISSUE_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_spurious_done();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
